// File: rtl/risc_pkg.sv
// Shared constants for the IITB-RISC execute stage.
//   DW / RW            : datapath and register-index widths
//   ALU_*              : 3-bit ALU operation codes
//   JMP_*              : 2-bit control-transfer codes
//   op_is_add/op_is_nand : classify ops by which flags they may write
package risc_pkg;

    localparam int DW = 16;
    localparam int RW = 3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_ADC  = 3'b001;
    localparam logic [2:0] ALU_ADZ  = 3'b010;
    localparam logic [2:0] ALU_NDU  = 3'b011;
    localparam logic [2:0] ALU_NDC  = 3'b100;
    localparam logic [2:0] ALU_NDZ  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_BEQ  = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JLR  = 2'b11;

    function automatic logic op_is_add(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_ADC) || (op == ALU_ADZ);
    endfunction

    function automatic logic op_is_nand(input logic [2:0] op);
        return (op == ALU_NDU) || (op == ALU_NDC) || (op == ALU_NDZ);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   op, src0, src1   : operation code and operands
//   carry, zero      : current architectural flags (for conditional ops)
//   result           : ALU result
//   carry_new/zero_new : flag values the op would produce (current value if the op keeps it)
//   cond_ok          : 0 when a conditional op's flag condition is not met (squash)
//   eq               : src0 == src1, used for BEQ
module ex_alu #(
    parameter int DW = 16
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] src0,
    input  logic [DW-1:0] src1,
    input  logic          carry,
    input  logic          zero,
    output logic [DW-1:0] result,
    output logic          carry_new,
    output logic          zero_new,
    output logic          cond_ok,
    output logic          eq
);
    import risc_pkg::*;

    logic [DW:0]   sum;
    logic [DW-1:0] nand_res;
    logic [DW-1:0] diff;

    assign sum      = {1'b0, src0} + {1'b0, src1};
    assign nand_res = ~(src0 & src1);
    assign diff     = src0 - src1;
    assign eq       = (src0 == src1);

    always_comb begin
        result    = src1;
        carry_new = carry;
        zero_new  = zero;
        cond_ok   = 1'b1;
        case (op)
            ALU_ADD, ALU_ADC, ALU_ADZ: begin
                result    = sum[DW-1:0];
                carry_new = sum[DW];
                zero_new  = (sum[DW-1:0] == '0);
            end
            ALU_NDU, ALU_NDC, ALU_NDZ: begin
                result   = nand_res;
                zero_new = (nand_res == '0);
            end
            ALU_SUB:  result = diff;
            default:  result = src1;
        endcase
        case (op)
            ALU_ADC, ALU_NDC: cond_ok = carry;
            ALU_ADZ, ALU_NDZ: cond_ok = zero;
            default:          cond_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage fused with the EX/MEM pipeline register. Owns the carry/zero
// flags, resolves BEQ/JAL/JLR into a one-cycle redirect/flush, and tracks halt.
// State updates on the falling clock edge; reset is synchronous, active-high.
// Optional feature: define EX_BYPASS_EN to drive byp_* with a copy of the
// EX/MEM destination/result for RR-stage forwarding; otherwise byp_* are 0.
// Ports:
//   in_*         : RR/EX pipeline-register contents
//   stall_ex     : MEM busy, hold everything
//   out_*        : EX/MEM pipeline-register contents, flags, redirect, halt
//   byp_*        : forwarding tap
module ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_pc,
    input  logic          in_lhi,
    input  logic [DW-1:0] in_m_addr,
    input  logic [DW-1:0] in_src0,
    input  logic [DW-1:0] in_src1,
    input  logic [DW-1:0] in_data_in,
    input  logic [RW-1:0] in_rdest,
    input  logic [2:0]    in_alu_op,
    input  logic          in_mem_ans,
    input  logic          in_w_mem,
    input  logic          in_w_reg,
    input  logic [1:0]    in_jump,
    input  logic          in_stop,
    input  logic          stall_ex,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic [DW-1:0] out_data_in,
    output logic [DW-1:0] out_pc,
    output logic [RW-1:0] out_rdest,
    output logic          out_mem_ans,
    output logic          out_w_mem,
    output logic          out_w_reg,
    output logic          out_carry,
    output logic          out_zero,
    output logic          out_redirect,
    output logic [DW-1:0] out_target,
    output logic          out_flush,
    output logic          out_halted,
    output logic          byp_valid,
    output logic [RW-1:0] byp_rdest,
    output logic [DW-1:0] byp_data
);
    import risc_pkg::*;

    logic [DW-1:0] alu_result;
    logic          alu_carry_new;
    logic          alu_zero_new;
    logic          alu_cond_ok;
    logic          alu_eq;

    // Set on a taken transfer; the next unstalled edge discards whatever
    // arrives, since upstream is flushed in the same cycle. Survives stalls.
    logic          kill_pending;

    logic          live;
    logic          is_jump;
    logic          squash;
    logic          taken;
    logic          flag_wr;
    logic          carry_wr;
    logic          zero_wr;
    logic [DW-1:0] result_next;
    logic [DW-1:0] target_next;

    ex_alu #(.DW(DW)) u_alu (
        .op        (in_alu_op),
        .src0      (in_src0),
        .src1      (in_src1),
        .carry     (out_carry),
        .zero      (out_zero),
        .result    (alu_result),
        .carry_new (alu_carry_new),
        .zero_new  (alu_zero_new),
        .cond_ok   (alu_cond_ok),
        .eq        (alu_eq)
    );

    always_comb begin
        live    = in_valid & ~out_halted & ~kill_pending;
        is_jump = (in_jump != JMP_NONE);
        // Flag conditions only gate ordinary ALU instructions.
        squash  = ~alu_cond_ok & ~in_lhi & ~is_jump;
        // A halting instruction never redirects, even if malformed as a jump.
        taken   = ~in_stop & (((in_jump == JMP_BEQ) & alu_eq) |
                              (in_jump == JMP_JAL) | (in_jump == JMP_JLR));
        // Only register-writing ALU ops move the flags; LW keeps carry.
        flag_wr  = in_w_reg & ~squash & ~in_stop & ~in_lhi & ~is_jump;
        carry_wr = flag_wr & op_is_add(in_alu_op) & ~in_mem_ans;
        zero_wr  = flag_wr & (op_is_add(in_alu_op) | op_is_nand(in_alu_op));

        result_next = alu_result;
        if (in_lhi)
            result_next = {in_src1[8:0], {(DW-9){1'b0}}};
        else if ((in_jump == JMP_JAL) || (in_jump == JMP_JLR))
            result_next = in_pc + {{(DW-1){1'b0}}, 1'b1};

        target_next = (in_jump == JMP_JLR) ? in_src1 : in_m_addr;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_data_in  <= '0;
            out_pc       <= '0;
            out_rdest    <= '0;
            out_mem_ans  <= 1'b0;
            out_w_mem    <= 1'b0;
            out_w_reg    <= 1'b0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_halted   <= 1'b0;
            kill_pending <= 1'b0;
        end else if (stall_ex) begin
            out_redirect <= 1'b0;
        end else begin
            out_redirect <= 1'b0;
            kill_pending <= 1'b0;
            if (!live) begin
                out_valid <= 1'b0;
                out_w_reg <= 1'b0;
                out_w_mem <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                out_result  <= result_next;
                out_data_in <= in_data_in;
                out_pc      <= in_pc;
                out_rdest   <= in_rdest;
                out_mem_ans <= in_mem_ans;
                out_w_mem   <= in_w_mem;
                out_w_reg   <= in_w_reg & ~squash & ~in_stop;
                if (in_stop)
                    out_halted <= 1'b1;
                if (taken) begin
                    out_redirect <= 1'b1;
                    out_target   <= target_next;
                    kill_pending <= 1'b1;
                end
                if (carry_wr)
                    out_carry <= alu_carry_new;
                if (zero_wr)
                    out_zero <= alu_zero_new;
            end
        end
    end

    assign out_flush = out_redirect;

`ifdef EX_BYPASS_EN
    assign byp_valid = out_valid & out_w_reg;
    assign byp_rdest = out_rdest;
    assign byp_data  = out_result;
`else
    assign byp_valid = 1'b0;
    assign byp_rdest = '0;
    assign byp_data  = '0;
`endif

endmodule
